bash_line_responder: RTL and testbench

BASH_LINE_RESPONDER -- requirements
Module: bash_line_responder

---
 rtl/bash_line_responder_if.sv | 20 ++
 rtl/bash_line_responder.sv | 96 +++++++++
 tb/tb_bash_line_responder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/bash_line_responder_if.sv
// bash_line_responder_if: terminal-side command line and response handshakes.
interface bash_line_responder_if;
    logic       line_ready;
    logic [5:0] line_len;
    logic [7:0] line_char;
    logic       line_next;
    logic       resp_ready;
    logic [7:0] resp_char;
    logic       resp_next;
    logic       solved;
    logic       solved_ack;
    modport master (
        output line_ready, line_len, line_char, resp_next, solved_ack,
        input  line_next, resp_ready, resp_char, solved
    );
    modport slave (
        input  line_ready, line_len, line_char, resp_next, solved_ack,
        output line_next, resp_ready, resp_char, solved
    );
endinterface

// File: rtl/bash_line_responder.sv
// bash_line_responder: buffers a command line, answers "echo" or "command not found".
module bash_line_responder #(
    parameter int MAX_LEN = 32
) (
    input logic                  clk,
    input logic                  rst,
    bash_line_responder_if.slave bus
);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [5:0] MAX6 = 6'(MAX_LEN);
    localparam logic [255:0] MSG = {"command not found", 120'h0};
    localparam logic [5:0] MSG_LEN = 6'd17;
    typedef enum logic [2:0] {IDLE, RECV, GAP, PARSE, SEND, SOLVE, WAIT_ACK} state_t;
    state_t     r_state;
    logic [7:0] r_buf [MAX_LEN];
    logic [5:0] r_cnt, r_len, r_idx, r_end;
    logic       r_echo, r_line_next, r_resp_ready, r_solved;
    logic [7:0] r_resp_char;
    logic       w_recv_done, w_store, w_parse_echo, w_lk_echo;
    logic [5:0] w_lk_idx, w_lk_end;
    logic [7:0] w_msg_char, w_lk_char;
    assign w_recv_done  = !bus.line_ready || bus.line_char == 8'h00 || r_cnt == bus.line_len;
    assign w_store      = r_state == RECV && !w_recv_done && r_cnt < MAX6;
    assign w_parse_echo = r_len >= 6'd4 && r_buf[0] == "e" && r_buf[1] == "c" &&
                          r_buf[2] == "h" && r_buf[3] == "o" &&
                          (r_len == 6'd4 || r_buf[4] == 8'h20);
    // Look-up targets the first character in PARSE and the following one in SEND
    assign w_lk_idx   = r_state == PARSE ? (w_parse_echo ? 6'd5 : 6'd0) : r_idx + 6'd1;
    assign w_lk_end   = r_state == PARSE ? (w_parse_echo ? r_len : MSG_LEN) : r_end;
    assign w_lk_echo  = r_state == PARSE ? w_parse_echo : r_echo;
    assign w_msg_char = MSG[8'd255 - {w_lk_idx[4:0], 3'b000} -: 8];
    assign w_lk_char  = w_lk_idx >= w_lk_end ? 8'h00 :
                        w_lk_echo ? r_buf[w_lk_idx[AW-1:0]] : w_msg_char;
    assign bus.line_next  = r_line_next;
    assign bus.resp_ready = r_resp_ready;
    assign bus.resp_char  = r_resp_char;
    assign bus.solved     = r_solved;
    always_ff @(posedge clk)
        if (w_store) r_buf[r_cnt[AW-1:0]] <= bus.line_char;
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cnt        <= 6'd0;
            r_len        <= 6'd0;
            r_idx        <= 6'd0;
            r_end        <= 6'd0;
            r_echo       <= 1'b0;
            r_line_next  <= 1'b0;
            r_resp_ready <= 1'b0;
            r_resp_char  <= 8'h00;
            r_solved     <= 1'b0;
        end else begin
            r_line_next <= 1'b0;
            r_solved    <= 1'b0;
            case (r_state)
                IDLE: if (bus.line_ready) begin
                    r_cnt   <= 6'd0;
                    r_len   <= 6'd0;
                    r_state <= RECV;
                end
                RECV: if (w_recv_done) r_state <= PARSE;
                else begin
                    if (w_store) r_len <= r_cnt + 6'd1;
                    r_cnt       <= r_cnt + 6'd1;
                    r_line_next <= 1'b1;
                    r_state     <= GAP;
                end
                GAP: r_state <= bus.line_ready ? RECV : PARSE;
                PARSE: if (r_len == 6'd0) begin
                    r_solved <= 1'b1;
                    r_state  <= SOLVE;
                end else begin
                    r_idx        <= w_lk_idx;
                    r_end        <= w_lk_end;
                    r_echo       <= w_parse_echo;
                    r_resp_char  <= w_lk_char;
                    r_resp_ready <= 1'b1;
                    r_state      <= SEND;
                end
                SEND: if (bus.resp_next) begin
                    if (r_resp_char == 8'h00) begin
                        r_resp_ready <= 1'b0;
                        r_solved     <= 1'b1;
                        r_state      <= SOLVE;
                    end else begin
                        r_idx       <= w_lk_idx;
                        r_resp_char <= w_lk_char;
                    end
                end
                SOLVE: r_state <= WAIT_ACK;
                WAIT_ACK: if (bus.solved_ack) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bash_line_responder.sv
// tb_bash_line_responder: directed terminal transactions against bash_line_responder.
module tb_bash_line_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    bash_line_responder_if bus ();
    bash_line_responder #(.MAX_LEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    int checks = 0, errors = 0;
    int n_solved = 0, n_multi = 0, n_rr = 0;
    logic [7:0] mem [64];
    int mlen = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    always @(negedge clk) begin
        if (bus.solved) n_solved++;
        if (bus.resp_ready) n_rr++;
        if (int'(bus.solved) + int'(bus.resp_ready) + int'(bus.line_next) > 1) n_multi++;
    end
    task automatic load(input string s);
        mlen = s.len();
        for (int i = 0; i < mlen; i++) mem[i] = s[i];
    endtask
    task automatic send_line(input int len, output int pulses, output bit gap_ok, output int lat);
        int tidx;
        bit prev;
        tidx = 0; pulses = 0; gap_ok = 1; prev = 0; lat = -1;
        bus.line_len = 6'(len);
        bus.line_char = mlen > 0 ? mem[0] : 8'h00;
        bus.line_ready = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (bus.line_next) begin
                pulses++;
                if (prev) gap_ok = 0;
                tidx++;
                bus.line_char = tidx < mlen ? mem[tidx] : 8'h00;
            end
            prev = bus.line_next;
            if (bus.resp_ready || bus.solved) begin
                lat = c;
                break;
            end
        end
        bus.line_ready = 1'b0;
    endtask
    task automatic collect(input int stall_at, output string got, output bit ok, output bit stable);
        logic [7:0] ch;
        int n;
        got = ""; ok = 0; stable = 1; n = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!bus.resp_ready) continue;
            ch = bus.resp_char;
            if (n == stall_at) begin
                repeat (100) begin
                    @(negedge clk);
                    if (!bus.resp_ready || bus.resp_char !== ch) stable = 0;
                end
            end
            bus.resp_next = 1'b1;
            @(negedge clk);
            bus.resp_next = 1'b0;
            n++;
            if (ch == 8'h00) begin
                ok = 1;
                break;
            end
            got = {got, $sformatf("%c", ch)};
        end
    endtask
    task automatic finish_ack(input string tag, input int s0);
        check({tag, ":solved"}, 32'(bus.solved), 1);
        @(negedge clk);
        check({tag, ":solved_pulse"}, 32'(bus.solved), 0);
        repeat (3) @(negedge clk);
        check({tag, ":solved_count"}, n_solved - s0, 1);
        bus.solved_ack = 1'b1;
        @(negedge clk);
        bus.solved_ack = 1'b0;
    endtask
    task automatic txn(input string tag, input string line, input string exp, input int stall_at);
        int pulses, lat, s0;
        bit gap_ok, ok, stable;
        string got;
        load(line);
        s0 = n_solved;
        send_line(line.len(), pulses, gap_ok, lat);
        check({tag, ":pulses"}, pulses, line.len());
        check({tag, ":gap"}, 32'(gap_ok), 1);
        collect(stall_at, got, ok, stable);
        check({tag, ":terminated"}, 32'(ok), 1);
        check({tag, ":resp_len"}, got.len(), exp.len());
        check({tag, ":resp_text"}, 32'(got == exp), 1);
        if (got != exp) $display("info %s response '%s' wanted '%s'", tag, got, exp);
        if (stall_at >= 0) check({tag, ":stall_stable"}, 32'(stable), 1);
        finish_ack(tag, s0);
    endtask
    initial begin
        int pulses, lat, s0, r0;
        bit gap_ok;
        string long_line;
        bus.line_ready = 0; bus.line_len = 0; bus.line_char = 0;
        bus.resp_next = 0; bus.solved_ack = 0;
        repeat (3) @(negedge clk);
        check("rst:line_next", 32'(bus.line_next), 0);
        check("rst:resp_ready", 32'(bus.resp_ready), 0);
        check("rst:resp_char", 32'(bus.resp_char), 0);
        check("rst:solved", 32'(bus.solved), 0);
        rst = 1'b1;
        @(negedge clk);
        txn("echo_hi", "echo hi", "hi", -1);
        txn("ls", "ls", "command not found", -1);
        txn("echo_only", "echo", "", -1);
        txn("echox", "echox", "command not found", -1);
        txn("stall", "echo world", "world", 2);
        load("");
        s0 = n_solved; r0 = n_rr;
        send_line(0, pulses, gap_ok, lat);
        check("empty:pulses", pulses, 0);
        check("empty:latency", lat, 2);
        finish_ack("empty", s0);
        check("empty:resp_ready", n_rr - r0, 0);
        long_line = "echo ";
        for (int i = 0; i < 35; i++) long_line = {long_line, $sformatf("%c", 97 + i % 26)};
        txn("long", long_line, long_line.substr(5, 31), -1);
        load("echo hi");
        s0 = n_solved;
        send_line(7, pulses, gap_ok, lat);
        check("rst_send:in_send", 32'(bus.resp_ready), 1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_send:resp_ready", 32'(bus.resp_ready), 0);
        check("rst_send:resp_char", 32'(bus.resp_char), 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_send:no_solved", n_solved - s0, 0);
        txn("after_rst", "echo a", "a", -1);
        check("exclusive_outputs", n_multi, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
